// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
// Shared definitions for the register-file arbiter: the arbitration state
// encoding, the requester index constants and the default widths.
// Optional feature macro used by importers: REGFILE_ARB_LOCK_EN.
package regfile_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int REQ_CPU        = 0;
    localparam int REQ_DBG        = 1;

    localparam int DEFAULT_ADDR_W = 2;
    localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin pick. A requester is a candidate only if
// its eligibility bit is set; with two candidates the one named by i_prio wins.
// Ports:
//   i_req   [1:0]  raw request per requester
//   i_elig  [1:0]  eligibility mask (both set in normal arbitration)
//   i_prio         requester that wins a tie
//   o_gnt   [1:0]  one-hot grant (or zero)
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_elig,
    input  logic       i_prio,
    output logic [1:0] o_gnt
);

    logic [1:0] w_cand;

    assign w_cand = i_req & i_elig;

    always_comb begin
        o_gnt = 2'b00;
        if (w_cand == 2'b11) begin
            o_gnt[REQ_DBG] = i_prio;
            o_gnt[REQ_CPU] = ~i_prio;
        end else begin
            o_gnt = w_cand;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// General-purpose register file shared between the CPU controller (requester 0)
// and the debug/loader port (requester 1). At most one access is granted per
// cycle by round-robin; writes commit at the end of the grant cycle, read data
// is registered and returned one cycle after the grant. Registers 0 and 1 are
// exported for the HEX displays.
// Optional feature: define REGFILE_ARB_LOCK_EN to honour lock_i (LOCKED state,
// owner and lock_cnt). Without it lock_i is ignored and locked_o is 0.
// Ports:
//   clock_pulse, reset          clock, asynchronous active-high reset
//   req_i, we_i, lock_i [1:0]   request, write enable, lock request per requester
//   addr0_i/addr1_i, wdata0_i/wdata1_i   per-requester address and write data
//   gnt_o [1:0]                 combinational one-hot grant
//   rvalid_o [1:0], rdata_o     registered read response
//   dbg_r0_o, dbg_r1_o          live contents of registers 0 and 1
//   locked_o                    high while LOCKED
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOCK_MAX = 8
)(
    input  logic              clock_pulse,
    input  logic              reset,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [1:0]        lock_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] dbg_r0_o,
    output logic [DATA_W-1:0] dbg_r1_o,
    output logic              locked_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_prio;
    logic [DATA_W-1:0] r_rdata_p1;
    logic [1:0]        r_rvalid_p1;

    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // ---------------- grant stage (combinational) ----------------
    rr_arbiter2 u_rr (
        .i_req  (req_i),
        .i_elig (w_elig),
        .i_prio (r_prio),
        .o_gnt  (w_gnt)
    );

    // Grant is forced low while reset is held so no access is shown as taken.
    assign gnt_o   = reset ? 2'b00 : w_gnt;
    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[REQ_DBG];
    assign w_we    = w_sel ? we_i[REQ_DBG] : we_i[REQ_CPU];
    assign w_addr  = w_sel ? addr1_i  : addr0_i;
    assign w_wdata = w_sel ? wdata1_i : wdata0_i;

`ifdef REGFILE_ARB_LOCK_EN
    arb_state_e                       r_state;
    logic                             r_owner;
    logic [$clog2(LOCK_MAX+1)-1:0]    r_lock_cnt;

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    // While locked only the owner is eligible, even if it is not requesting.
    assign w_elig   = (r_state == LOCKED) ? (r_owner ? 2'b10 : 2'b01) : 2'b11;
    assign locked_o = (r_state == LOCKED);

    always_ff @(posedge clock_pulse or posedge reset) begin
        if (reset) begin
            r_state    <= ARB;
            r_owner    <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    // A lock limit of one would release on the same edge, so never lock.
                    if (w_any && lock_i[w_sel] && (LOCK_MAX > 1)) begin
                        r_state    <= LOCKED;
                        r_owner    <= w_sel;
                        r_lock_cnt <= CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!lock_i[r_owner]) begin
                        r_state    <= ARB;
                        r_lock_cnt <= '0;
                    end else if (w_any) begin
                        // Forced release; prio already moves to the non-owner
                        // because this edge ends a grant to the owner.
                        if (r_lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                            r_state    <= ARB;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ARB;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^lock_i;
    assign w_elig        = 2'b11;
    assign locked_o      = 1'b0;
`endif

    // ---------------- commit stage (grant-cycle edge) ----------------
    always_ff @(posedge clock_pulse or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_any) begin
            r_prio <= ~w_sel;
        end
    end

    always_ff @(posedge clock_pulse or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_any && w_we) begin
            r_regs[w_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clock_pulse or posedge reset) begin
        if (reset) begin
            r_rdata_p1  <= '0;
            r_rvalid_p1 <= 2'b00;
        end else begin
            r_rvalid_p1 <= w_gnt & ~we_i;
            if (w_any && !w_we) begin
                r_rdata_p1 <= r_regs[w_addr];
            end
        end
    end

    // ---------------- response stage (one cycle after grant) ----------------
    assign rdata_o  = r_rdata_p1;
    assign rvalid_o = r_rvalid_p1;
    assign dbg_r0_o = r_regs[0];
    assign dbg_r1_o = r_regs[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

    localparam int AW = 2;
    localparam int DW = 32;

`ifdef REGFILE_ARB_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, we, lock;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, dbg0, dbg1;
    logic          locked;

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model [4];
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(8)) dut (
        .clock_pulse (clk),
        .reset       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr0_i     (a0),
        .addr1_i     (a1),
        .wdata0_i    (d0),
        .wdata1_i    (d1),
        .lock_i      (lock),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .dbg_r0_o    (dbg0),
        .dbg_r1_o    (dbg1),
        .locked_o    (locked)
    );

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model[i] = '0;
        q.delete();
    endtask

    task automatic idle_inputs();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    // Drive one cycle's inputs and check the grant at the falling edge.
    task automatic phase_a(input logic [1:0] r, input logic [1:0] w,
                           input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                           input logic [DW-1:0] y0, input logic [DW-1:0] y1,
                           input logic [1:0] lk, input logic [1:0] exp_gnt,
                           input logic exp_lock, input string name);
        exp_t e;
        req = r; we = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1; lock = lk;
        @(negedge clk);
        tests++;
        if (gnt !== exp_gnt) begin
            fails++;
            $display("FAIL %s gnt: got %b expected %b", name, gnt, exp_gnt);
        end
        tests++;
        if (locked !== exp_lock) begin
            fails++;
            $display("FAIL %s locked: got %b expected %b", name, locked, exp_lock);
        end
        if (exp_gnt == 2'b01) begin
            if (w[0]) model[x0] = y0;
            else begin e.vld = 2'b01; e.data = model[x0]; q.push_back(e); end
        end else if (exp_gnt == 2'b10) begin
            if (w[1]) model[x1] = y1;
            else begin e.vld = 2'b10; e.data = model[x1]; q.push_back(e); end
        end
    endtask

    // After the rising edge: pop the scoreboard and check the read response.
    task automatic phase_b(input string name);
        exp_t e;
        @(posedge clk); #1;
        tests++;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (rvalid !== e.vld || rdata !== e.data) begin
                fails++;
                $display("FAIL %s read: got vld=%b data=%h expected vld=%b data=%h",
                         name, rvalid, rdata, e.vld, e.data);
            end
        end else if (rvalid !== 2'b00) begin
            fails++;
            $display("FAIL %s rvalid: got %b expected 00", name, rvalid);
        end
        tests++;
        if (dbg0 !== model[0] || dbg1 !== model[1]) begin
            fails++;
            $display("FAIL %s dbg: got r0=%h r1=%h expected r0=%h r1=%h",
                     name, dbg0, dbg1, model[0], model[1]);
        end
    endtask

    task automatic cyc(input logic [1:0] r, input logic [1:0] w,
                       input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                       input logic [DW-1:0] y0, input logic [DW-1:0] y1,
                       input logic [1:0] lk, input logic [1:0] exp_gnt,
                       input logic exp_lock, input string name);
        phase_a(r, w, x0, x1, y0, y1, lk, exp_gnt, exp_lock, name);
        phase_b(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        tests++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata !== '0 || locked !== 1'b0 ||
            dbg0 !== '0 || dbg1 !== '0) begin
            fails++;
            $display("FAIL reset_init: got gnt=%b rvalid=%b rdata=%h locked=%b r0=%h r1=%h expected all zero",
                     gnt, rvalid, rdata, locked, dbg0, dbg1);
        end
        apply_reset();
        cyc(2'b01, 2'b01, 2'd0, 2'd0, 32'h11, 32'h0, 2'b00, 2'b01, 1'b0, "rst_w0");
        cyc(2'b11, 2'b10, 2'd0, 2'd1, 32'h0, 32'h22, 2'b10, 2'b10, 1'b0, "rst_w1_lock");
        phase_a(2'b10, 2'b00, 2'd0, 2'd1, 32'h0, 32'h0, 2'b10, 2'b10, LK, "rst_rd_locked");
        // Reset while the read is in flight: the response must never appear.
        rst = 1'b1;
        q.delete();
        #1;
        tests++;
        if (gnt !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid gnt: got %b expected 00", gnt);
        end
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 2'b00 || locked !== 1'b0 || dbg0 !== '0 || dbg1 !== '0 || rdata !== '0) begin
            fails++;
            $display("FAIL rst_mid: got rvalid=%b locked=%b r0=%h r1=%h rdata=%h expected zeros",
                     rvalid, locked, dbg0, dbg1, rdata);
        end
        rst = 1'b0;
        clear_model();
        idle_inputs();
    endtask

    task automatic test_write_read();
        apply_reset();
        cyc(2'b01, 2'b01, 2'd0, 2'd0, 32'h0000_00A5, 32'h0, 2'b00, 2'b01, 1'b0, "wr_a5");
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "rd_a5");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "rd_a5_resp");
        tests++;
        if (dbg0 !== 32'h0000_00A5) begin
            fails++;
            $display("FAIL dbg_r0_a5: got %h expected 000000a5", dbg0);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        cyc(2'b11, 2'b11, 2'd2, 2'd3, 32'hAAAA_0002, 32'hBBBB_0003, 2'b00, 2'b01, 1'b0, "cont0");
        cyc(2'b11, 2'b10, 2'd2, 2'd3, 32'h0, 32'hBBBB_0003, 2'b00, 2'b10, 1'b0, "cont1");
        cyc(2'b11, 2'b00, 2'd2, 2'd3, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "cont2");
        cyc(2'b11, 2'b00, 2'd2, 2'd3, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0, "cont3");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "cont_drain");
    endtask

    task automatic test_back_to_back();
        // Write by the debug port, then an immediate CPU read of the same register.
        cyc(2'b10, 2'b10, 2'd0, 2'd1, 32'h0, 32'hDEAD_BEEF, 2'b00, 2'b10, 1'b0, "b2b_wr");
        cyc(2'b01, 2'b00, 2'd1, 2'd0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "b2b_rd");
        cyc(2'b10, 2'b00, 2'd0, 2'd2, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0, "b2b_rd2");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "b2b_drain");
    endtask

    task automatic test_idle_prio();
        apply_reset();
        cyc(2'b01, 2'b00, 2'd3, 2'd0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "idle_g0");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "idle_none");
        cyc(2'b11, 2'b00, 2'd0, 2'd1, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0, "idle_both1");
        cyc(2'b11, 2'b00, 2'd0, 2'd1, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "idle_both2");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "idle_drain");
    endtask

    task automatic test_lock();
        logic [1:0] eg;
        logic       el;
        apply_reset();
        cyc(2'b01, 2'b01, 2'd3, 2'd0, 32'h3333_0003, 32'h0, 2'b00, 2'b01, 1'b0, "lock_pre");
        for (int k = 1; k <= 9; k++) begin
            if (LK) eg = (k <= 8) ? 2'b10 : 2'b01;
            else    eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            el = LK && (k >= 2) && (k <= 8);
            cyc(2'b11, 2'b00, 2'(k % 4), 2'((k + 1) % 4), 32'h0, 32'h0, 2'b10, eg, el,
                $sformatf("lock_k%0d", k));
        end
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "lock_drain");
    endtask

    task automatic test_lock_release();
        apply_reset();
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "rel_pre");
        cyc(2'b11, 2'b00, 2'd0, 2'd1, 32'h0, 32'h0, 2'b10, 2'b10, 1'b0, "rel_g1");
        cyc(2'b11, 2'b00, 2'd0, 2'd1, 32'h0, 32'h0, 2'b10, LK ? 2'b10 : 2'b01, LK, "rel_g2");
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, LK ? 2'b00 : 2'b01, LK, "rel_drop");
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0, "rel_after");
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, "rel_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_idle_prio();
        test_lock();
        test_lock_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Owns the CPU's general-purpose register file and shares it between two requesters: requester 0 is the fetch-decode-execute-writeback controller, and requester 1 is the switch-driven debug/loader port. Each cycle it grants at most one access using round-robin arbitration. Writes commit in the grant cycle, and read data returns one cycle later. It also exports the raw values of registers 0 and 1 for the HEX displays.

## Interface
- `ADDR_W`, default 2: register address width; the file holds 2**ADDR_W registers.
- `DATA_W`, default 32: register width.
- `LOCK_MAX`, default 8: maximum consecutive grant cycles a locked owner may hold.

- `clock_pulse`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  2  access request, one bit per requester.
- `we_i`  in  2  1 = write, 0 = read, per requester.
- `addr0_i` / `addr1_i`  in  ADDR_W  register index for requester 0 / 1.
- `wdata0_i` / `wdata1_i`  in  DATA_W  write data for requester 0 / 1.
- `lock_i`  in  2  lock request per requester (used only with the lock feature).
- `gnt_o`  out  2  one-hot grant, combinational from current state and `req_i`.
- `rvalid_o`  out  2  read data valid for that requester.
- `rdata_o`  out  DATA_W  registered read data.
- `dbg_r0_o` / `dbg_r1_o`  out  DATA_W  live contents of register 0 / 1.
- `locked_o`  out  1  high while the state is LOCKED.

## Operation
- **Request protocol:** a requester holds `req_i`, `we_i`, `addr`, and `wdata` stable until it sees `gnt_o`. The request is consumed in the grant cycle.
- **Arbitration:**
  - If only one requester asserts `req_i`, it is granted.
  - If both assert it, requester `prio` is granted.
  - After any grant to requester i, `prio` becomes the other requester.
- **Write:** at the rising edge that ends a grant cycle with `we_i`=1, the register is updated.
- **Read:** for a granted read, `rdata_o` takes the register value sampled in the grant cycle, and `rvalid_o[i]` pulses for exactly one cycle.
- **Read-after-write:** a read granted in the cycle after a write returns the new value.
- **Idle:** with no request, `gnt_o`=0 and `prio` is unchanged.
- **States:**
  - **ARB:** normal round-robin arbitration.
  - **LOCKED:** a single owner (`owner` bit) is the only requester that can be granted. The other requester waits, even if the owner is not requesting.
- **Transitions (lock feature enabled):**
  - ARB→LOCKED: on a grant to requester i with `lock_i[i]`=1. Then `owner`=i and `lock_cnt`=1.
  - While in LOCKED, each grant cycle to the owner increments `lock_cnt`.
  - LOCKED→ARB: when `lock_i[owner]`=0 (sampled at any edge), or on the edge where `lock_cnt` reaches `LOCK_MAX` (forced release).
  - On forced release, `prio` is set to the non-owner.
- **Reset values (asynchronous, take effect immediately):**
  - All registers 0.
  - `rdata_o`=0, `rvalid_o`=0, `gnt_o`=0, `locked_o`=0.
  - `prio`=0, state ARB, `lock_cnt`=0.
- **Reset mid-operation:** reset during LOCKED, or with a read outstanding, drops the lock and suppresses the pending `rvalid_o`.

## Timing
- Grant latency: 0 cycles. `gnt_o` is valid in the same cycle as `req_i` when the requester is eligible.
- Write commit: at the grant-cycle edge. `dbg_r*_o` reflect the new value one edge after the grant.
- Read latency: 1 cycle from grant to `rvalid_o`/`rdata_o`.
- Throughput: one access per cycle in total. Under contention each requester is served every second cycle.
- Starvation bounds: a requester waits at most 1 cycle in ARB, and at most `LOCK_MAX`+1 cycles while the other requester holds a lock.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined: `lock_i` is honoured, and the LOCKED state, `owner`, and `lock_cnt` are implemented.
- `REGFILE_ARB_LOCK_EN` undefined:
  - `lock_i` is ignored and the block stays in ARB permanently.
  - `locked_o` is tied to 0.
  - The ports stay present so instantiations are unchanged.

## Structure
- Shared package `regfile_arb_pkg` holds:
  - the state enum (ARB, LOCKED);
  - the requester index constants `REQ_CPU`=0 and `REQ_DBG`=1;
  - the default `ADDR_W`/`DATA_W` constants.
- One sub-module, `rr_arbiter2`: a combinational two-way round-robin pick from `req`, `prio`, and an eligibility mask, producing the one-hot grant.
- The register array, state, `prio`, and read-data registers stay in the top module.

## Test plan
- **Reset:** assert `reset` mid-LOCKED with a read in flight → next cycle `rvalid_o`=0, `locked_o`=0, `dbg_r0_o`=0, `dbg_r1_o`=0.
- **Write then read:** requester 0 writes 0x0000_00A5 to reg 0, then reads reg 0 the next cycle → `rvalid_o`=2'b01 with `rdata_o`=0x0000_00A5 one cycle after that grant; `dbg_r0_o`=0xA5.
- **Contention:** both requesters request continuously for 4 cycles after reset → grants 01, 10, 01, 10.
- **Lock:** requester 1 locks with continuous requests while requester 0 requests → requester 1 is granted; with `LOCK_MAX`=8, requester 0 is granted no later than the 9th cycle.
- **Lock release:** requester 1 drops `lock_i` after 2 grants → requester 0 is granted the following cycle.
- **Macro off:** repeat the lock scenario with the macro undefined → grants alternate and `locked_o` stays 0.
